// File: rtl/spin_flip_engine.sv
// Spin flip engine: flips up to MAX_FLIP LFSR-selected bits of an incoming spin vector.
// Optional macro SPIN_FLIP_ENGINE_STATS_EN builds a 32-bit output-handshake counter.
module spin_flip_engine #(
    parameter int NUM_SPIN = 256,
    parameter int MAX_FLIP = 16,
    parameter int FLIP_W   = $clog2(MAX_FLIP + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic                flush_i,
    input  logic                seed_load_i,
    input  logic [15:0]         seed_i,
    input  logic [FLIP_W-1:0]   flip_num_i,
    input  logic                spin_valid_i,
    input  logic [NUM_SPIN-1:0] spin_i,
    output logic                spin_ready_o,
    output logic                spin_push_valid_o,
    output logic [NUM_SPIN-1:0] spin_push_o,
    output logic                spin_push_none_o,
    input  logic                spin_push_ready_i,
    output logic                busy_o,
    output logic [31:0]         debug_push_cnt_o
);

    // state  | meaning
    // S_IDLE | waiting for an input vector
    // S_FLIP | one mask bit set per enabled cycle until the counter empties
    // S_OUT  | result held on the push interface until accepted

    localparam int          IDX_W    = $clog2(NUM_SPIN);
    localparam logic [15:0] LFSR_RST = 16'hACE1;

    typedef enum logic [1:0] {S_IDLE, S_FLIP, S_OUT} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [NUM_SPIN-1:0]   r_spin;
    logic [NUM_SPIN-1:0]   r_mask;
    logic [FLIP_W-1:0]     r_cnt;
    logic [15:0]           r_lfsr;
    logic                  r_push_valid;
    logic [NUM_SPIN-1:0]   r_push_data;
    logic                  r_push_none;

    logic                  w_in_hs;
    logic                  w_out_hs;
    logic                  w_flip_step;
    logic                  w_last_flip;
    logic [FLIP_W-1:0]     w_load_cnt;
    logic [IDX_W-1:0]      w_idx;
    logic [NUM_SPIN-1:0]   w_mask_set;
    logic [15:0]           w_lfsr_nxt;

    assign w_in_hs     = spin_valid_i & spin_ready_o;
    assign w_out_hs    = r_push_valid & spin_push_ready_i & ~flush_i;
    assign w_last_flip = (r_cnt == FLIP_W'(1));
    assign w_load_cnt  = (flip_num_i > FLIP_W'(MAX_FLIP)) ? FLIP_W'(MAX_FLIP) : flip_num_i;
    assign w_idx       = r_lfsr[IDX_W-1:0];
    assign w_lfsr_nxt  = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

    // Duplicate indices OR into the mask, so distinct flips may fall short of the request.
    always_comb begin
        w_mask_set        = r_mask;
        w_mask_set[w_idx] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush_i) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_in_hs)
                            w_state_nxt = (w_load_cnt == '0) ? S_OUT : S_FLIP;
                S_FLIP: if (w_flip_step && w_last_flip)
                            w_state_nxt = S_OUT;
                S_OUT:  if (w_out_hs)
                            w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        spin_ready_o = en_i & (r_state == S_IDLE) & ~flush_i;
        busy_o       = (r_state != S_IDLE);
        w_flip_step  = en_i & (r_state == S_FLIP) & ~flush_i;
    end

    // Result is registered on entry to S_OUT so the push outputs never depend on en_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_spin       <= '0;
            r_mask       <= '0;
            r_cnt        <= '0;
            r_push_valid <= 1'b0;
            r_push_data  <= '0;
            r_push_none  <= 1'b0;
        end else if (flush_i) begin
            r_mask       <= '0;
            r_push_valid <= 1'b0;
            r_push_data  <= '0;
            r_push_none  <= 1'b0;
        end else if (w_in_hs) begin
            r_spin <= spin_i;
            r_mask <= '0;
            r_cnt  <= w_load_cnt;
            if (w_load_cnt == '0) begin
                r_push_valid <= 1'b1;
                r_push_data  <= spin_i;
                r_push_none  <= 1'b1;
            end
        end else if (w_flip_step) begin
            r_mask <= w_mask_set;
            r_cnt  <= r_cnt - FLIP_W'(1);
            if (w_last_flip) begin
                r_push_valid <= 1'b1;
                r_push_data  <= r_spin ^ w_mask_set;
                r_push_none  <= 1'b0;
            end
        end else if (w_out_hs) begin
            r_push_valid <= 1'b0;
            r_push_data  <= '0;
            r_push_none  <= 1'b0;
        end
    end

    // A zero seed would lock the LFSR, so it is replaced by the reset constant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)          r_lfsr <= LFSR_RST;
        else if (seed_load_i) r_lfsr <= (seed_i == 16'h0000) ? LFSR_RST : seed_i;
        else if (w_flip_step) r_lfsr <= w_lfsr_nxt;
    end

    assign spin_push_valid_o = r_push_valid;
    assign spin_push_o       = r_push_data;
    assign spin_push_none_o  = r_push_none;

`ifdef SPIN_FLIP_ENGINE_STATS_EN
    logic [31:0] r_push_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)       r_push_cnt <= '0;
        else if (w_out_hs) r_push_cnt <= r_push_cnt + 32'd1;
    end

    assign debug_push_cnt_o = r_push_cnt;
`else
    assign debug_push_cnt_o = '0;
`endif

endmodule
